// File: rtl/exe_operand_stage_if.sv
// Bundle of the decode-side, hazard-side and execute-side signals of
// exe_operand_stage.
//   master : environment side (decode, EX/MEM feedback, EX consumer)
//   slave  : the operand stage itself
// Decode side : in_valid/in_ready handshake plus instruction fields
// Hazard side : ex_* / mem_* destination info and results, flush
// EX side     : out_valid/out_ready handshake plus operands and passthroughs
interface exe_operand_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [4:0]  in_rs1_addr;
    logic [4:0]  in_rs2_addr;
    logic [31:0] in_rs1_data;
    logic [31:0] in_rs2_data;
    logic [31:0] in_imm;
    logic [1:0]  in_op1_sel;
    logic [1:0]  in_op2_sel;
    logic [3:0]  in_alu_op;
    logic        in_store;
    logic [4:0]  in_rd_addr;
    logic        in_rd_wen;

    logic [4:0]  ex_rd_addr;
    logic        ex_rd_wen;
    logic        ex_is_load;
    logic [31:0] ex_result;
    logic [4:0]  mem_rd_addr;
    logic        mem_rd_wen;
    logic [31:0] mem_result;
    logic        flush;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] oper1;
    logic [31:0] oper2;
    logic [3:0]  alu_op;
    logic [31:0] store_data;
    logic [31:0] out_pc;
    logic [4:0]  out_rd_addr;
    logic        out_rd_wen;
    logic        out_store;

    modport master (
        output in_valid, in_pc, in_rs1_addr, in_rs2_addr, in_rs1_data,
               in_rs2_data, in_imm, in_op1_sel, in_op2_sel, in_alu_op,
               in_store, in_rd_addr, in_rd_wen,
               ex_rd_addr, ex_rd_wen, ex_is_load, ex_result,
               mem_rd_addr, mem_rd_wen, mem_result, flush, out_ready,
        input  in_ready, out_valid, oper1, oper2, alu_op, store_data,
               out_pc, out_rd_addr, out_rd_wen, out_store
    );

    modport slave (
        input  in_valid, in_pc, in_rs1_addr, in_rs2_addr, in_rs1_data,
               in_rs2_data, in_imm, in_op1_sel, in_op2_sel, in_alu_op,
               in_store, in_rd_addr, in_rd_wen,
               ex_rd_addr, ex_rd_wen, ex_is_load, ex_result,
               mem_rd_addr, mem_rd_wen, mem_result, flush, out_ready,
        output in_ready, out_valid, oper1, oper2, alu_op, store_data,
               out_pc, out_rd_addr, out_rd_wen, out_store
    );
endinterface

// File: rtl/exe_operand_stage.sv
// Decode-to-execute pipeline register. Builds ALU operands with EX/MEM
// forwarding, inserts one bubble on a load-use hazard, and squashes on flush.
// Ports:
//   clk  : single clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : exe_operand_stage_if.slave (decode handshake, EX/MEM feedback,
//          flush, execute handshake, operands and passthrough fields)
module exe_operand_stage (
    input logic              clk,
    input logic              rst,
    exe_operand_stage_if.slave bus
);

    logic        out_valid_q;
    logic [31:0] oper1_q;
    logic [31:0] oper2_q;
    logic [3:0]  alu_op_q;
    logic [31:0] store_data_q;
    logic [31:0] out_pc_q;
    logic [4:0]  out_rd_addr_q;
    logic        out_rd_wen_q;
    logic        out_store_q;

    logic [31:0] fwd_rs1;
    logic [31:0] fwd_rs2;
    logic        rs1_used;
    logic        rs2_used;
    logic        hazard;
    logic        load;
    logic [31:0] oper1_d;
    logic [31:0] oper2_d;

    // A load in EX has no result yet, so it is excluded from EX forwarding;
    // that case is covered by the load-use bubble instead.
    function automatic logic [31:0] fwd_value(
        input logic [4:0]  src,
        input logic [31:0] rf_data,
        input logic [4:0]  ex_rd,
        input logic        ex_wen,
        input logic        ex_load,
        input logic [31:0] ex_res,
        input logic [4:0]  mem_rd,
        input logic        mem_wen,
        input logic [31:0] mem_res
    );
        logic [31:0] v;
        if (src == 5'd0)
            v = 32'd0;
        else if (ex_wen && ex_rd == src && !ex_load)
            v = ex_res;
        else if (mem_wen && mem_rd == src)
            v = mem_res;
        else
            v = rf_data;
        return v;
    endfunction

    always_comb begin
        fwd_rs1 = fwd_value(bus.in_rs1_addr, bus.in_rs1_data, bus.ex_rd_addr,
                            bus.ex_rd_wen, bus.ex_is_load, bus.ex_result,
                            bus.mem_rd_addr, bus.mem_rd_wen, bus.mem_result);
        fwd_rs2 = fwd_value(bus.in_rs2_addr, bus.in_rs2_data, bus.ex_rd_addr,
                            bus.ex_rd_wen, bus.ex_is_load, bus.ex_result,
                            bus.mem_rd_addr, bus.mem_rd_wen, bus.mem_result);

        rs1_used = (bus.in_op1_sel == 2'd0);
        rs2_used = (bus.in_op2_sel == 2'd0) || bus.in_store;

        hazard = bus.in_valid && bus.ex_is_load && bus.ex_rd_wen &&
                 (bus.ex_rd_addr != 5'd0) &&
                 ((rs1_used && bus.ex_rd_addr == bus.in_rs1_addr) ||
                  (rs2_used && bus.ex_rd_addr == bus.in_rs2_addr));

        load = bus.out_ready || !out_valid_q;

        unique case (bus.in_op1_sel)
            2'd0:    oper1_d = fwd_rs1;
            2'd1:    oper1_d = bus.in_pc;
            default: oper1_d = 32'd0;
        endcase

        unique case (bus.in_op2_sel)
            2'd0:    oper2_d = fwd_rs2;
            2'd1:    oper2_d = bus.in_imm;
            2'd2:    oper2_d = 32'd4;
            default: oper2_d = 32'd0;
        endcase
    end

    // Flush always frees the stage, even when EX is stalled or a hazard is seen.
    assign bus.in_ready = !rst && (bus.flush || (load && !hazard));

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q   <= 1'b0;
            oper1_q       <= 32'd0;
            oper2_q       <= 32'd0;
            alu_op_q      <= 4'd0;
            store_data_q  <= 32'd0;
            out_pc_q      <= 32'd0;
            out_rd_addr_q <= 5'd0;
            out_rd_wen_q  <= 1'b0;
            out_store_q   <= 1'b0;
        end else if (bus.flush) begin
            out_valid_q <= 1'b0;
        end else if (load && hazard) begin
            out_valid_q <= 1'b0;
        end else if (load) begin
            out_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                oper1_q       <= oper1_d;
                oper2_q       <= oper2_d;
                alu_op_q      <= bus.in_alu_op;
                store_data_q  <= fwd_rs2;
                out_pc_q      <= bus.in_pc;
                out_rd_addr_q <= bus.in_rd_addr;
                out_rd_wen_q  <= bus.in_rd_wen;
                out_store_q   <= bus.in_store;
            end
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.oper1       = oper1_q;
    assign bus.oper2       = oper2_q;
    assign bus.alu_op      = alu_op_q;
    assign bus.store_data  = store_data_q;
    assign bus.out_pc      = out_pc_q;
    assign bus.out_rd_addr = out_rd_addr_q;
    assign bus.out_rd_wen  = out_rd_wen_q;
    assign bus.out_store   = out_store_q;

endmodule
